// File: rtl/ceres_param.sv
// Shared parameters and types for the instruction-side refill path.
package ceres_param;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } ilowX_res_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } imem_rsp_state_e;

endpackage

// File: rtl/imem_refill_responder.sv
// Answers instruction-cache line refills by reading the line word by word from memory,
// one read in flight at a time; uncached requests fetch only the addressed word.
module imem_refill_responder #(
  parameter int unsigned BLK_SIZE = ceres_param::BLK_SIZE,
  parameter int unsigned XLEN     = ceres_param::XLEN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  ceres_param::ilowX_req_t lx_ireq_i,
  output ceres_param::ilowX_res_t lx_ires_o,
  output logic                   mem_req_o,
  output logic [XLEN-1:0]        mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [XLEN-1:0]        mem_rdata_i
);
  import ceres_param::*;

  localparam int unsigned WORDS = BLK_SIZE / XLEN;
  localparam int unsigned CW    = $clog2(WORDS);

  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || WORDS * XLEN != BLK_SIZE) begin : g_bad_words
    $error("imem_refill_responder: BLK_SIZE/XLEN must be a power of two >= 2");
  end
  if (BLK_SIZE != ceres_param::BLK_SIZE) begin : g_bad_blk
    $error("imem_refill_responder: BLK_SIZE must match the response type width");
  end

  imem_rsp_state_e       state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         widx_q, widx_d;
  logic [XLEN-1:0]       base_q, base_d;
  logic                  unc_q, unc_d;
  logic [BLK_SIZE-1:0]   line_q, line_d;
  logic                  mem_req_q, mem_req_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [CW-1:0]         lane;
  logic                  unused_req_ready;

  // The cache always consumes the response, so its ready is not needed.
  assign unused_req_ready = lx_ireq_i.ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    base_d     = base_q;
    unc_d      = unc_q;
    line_d     = line_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    valid_d    = 1'b0;
    ready_d    = 1'b0;
    lane       = unc_q ? widx_q : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (lx_ireq_i.valid && ready_q) begin
          base_d     = lx_ireq_i.addr & ~XLEN'(BLK_SIZE / 8 - 1);
          widx_d     = CW'(lx_ireq_i.addr >> 2);
          unc_d      = lx_ireq_i.uncached;
          cnt_d      = '0;
          line_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = base_d + (XLEN'(lx_ireq_i.uncached ? widx_d : CW'(0)) << 2);
          state_d    = ISSUE;
        end else begin
          ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          state_d = WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (lane == CW'(i)) line_d[i*XLEN +: XLEN] = mem_rdata_i;
          end
          if (unc_q || cnt_q == CW'(WORDS - 1)) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            mem_req_d  = 1'b1;
            mem_addr_d = base_q + (XLEN'(cnt_d) << 2);
            state_d    = ISSUE;
          end
        end
      end
      RESP: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      base_q     <= '0;
      unc_q      <= 1'b0;
      line_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      base_q     <= base_d;
      unc_q      <= unc_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign lx_ires_o  = '{valid: valid_q, ready: ready_q, blk: line_q};

  // Read data with nothing outstanding indicates a broken memory handshake.
  a_rvalid_in_wait : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> state_q == WAIT)
    else $error("mem_rvalid_i seen outside WAIT");

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder with a zero-wait memory model and
// optional grant stalls on a chosen word.
module tb_imem_refill_responder;
  import ceres_param::*;

  logic             clk = 1'b0;
  logic             rst_n;
  ilowX_req_t       req;
  ilowX_res_t       res;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;

  logic             pend = 1'b0;
  logic [31:0]      pend_data = '0;
  logic             data_mode = 1'b0;
  logic [31:0]      const_data = '0;
  logic [31:0]      beats[$];
  int               word_cnt = 0;
  int               stall_word = -1;
  int               stall_left = 0;
  int               stall_seen = 0;
  int               stall_bad = 0;
  logic [31:0]      stall_ref = '0;

  always #5 clk = ~clk;

  imem_refill_responder #(.BLK_SIZE(128), .XLEN(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .lx_ireq_i    (req),
    .lx_ires_o    (res),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // One clock step plus the memory model: grant when requested (unless stalled), data one cycle later.
  task automatic tick();
    @(posedge clk); #1; cyc++;
    mem_rvalid = pend; mem_rdata = pend_data; pend = 1'b0;
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (word_cnt == stall_word && stall_left > 0) begin
        if (stall_seen == 0) stall_ref = mem_addr;
        else if (mem_addr != stall_ref) stall_bad++;
        stall_seen++; stall_left--;
      end else begin
        if (word_cnt == stall_word && stall_seen > 0 && mem_addr != stall_ref) stall_bad++;
        mem_gnt = 1'b1; pend = 1'b1;
        pend_data = data_mode ? const_data : mem_addr;
        beats.push_back(mem_addr); word_cnt++;
      end
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic unc, output int t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res.ready) begin ok = 1'b1; break; end
      tick();
    end
    beats.delete(); word_cnt = 0;
    req = '{valid: 1'b1, ready: 1'b1, addr: addr, uncached: unc};
    t = cyc;
    tick();
    req.valid = 1'b0;
  endtask

  task automatic run_observe(input int max, output int vcyc, output int vcnt, output logic [127:0] blk);
    vcyc = -1; vcnt = 0; blk = '0;
    for (int i = 0; i < max; i++) begin
      if (res.valid) begin
        if (vcyc < 0) begin vcyc = cyc; blk = res.blk; end
        vcnt++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", res.ready); end
    checks++; if (res.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res.valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (res.blk !== 128'h0) begin errors++; $display("FAIL reset_blk: got %h expected 0", res.blk); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    rst_n = 1'b1;
    tick();
    checks++; if (res.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", res.ready); end
  endtask

  task automatic test_cached();
    int t, vcyc, vcnt; bit ok; logic [127:0] blk;
    data_mode = 1'b0;
    start_req(32'h8000_0014, 1'b0, t, ok);
    run_observe(20, vcyc, vcnt, blk);
    checks++; if (!ok) begin errors++; $display("FAIL cached_ready_timeout: got 0 expected 1"); end
    checks++; if (beats.size() != 4) begin errors++; $display("FAIL cached_beats: got %0d expected 4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i] !== 32'h8000_0010 + 32'(4 * i)) begin
        errors++; $display("FAIL cached_addr%0d: got %h expected %h", i, beats[i], 32'h8000_0010 + 32'(4 * i));
      end
    end
    checks++; if (blk !== {32'h8000_001C, 32'h8000_0018, 32'h8000_0014, 32'h8000_0010}) begin
      errors++; $display("FAIL cached_blk: got %h expected 8000001c800000188000001480000010", blk); end
    checks++; if (vcyc != t + 9) begin errors++; $display("FAIL cached_latency: got %0d expected %0d", vcyc - t, 9); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL cached_valid_cycles: got %0d expected 1", vcnt); end
  endtask

  task automatic test_uncached();
    int t, vcyc, vcnt; bit ok; logic [127:0] blk;
    data_mode = 1'b1; const_data = 32'hDEAD_BEEF;
    start_req(32'h2000_0008, 1'b1, t, ok);
    run_observe(12, vcyc, vcnt, blk);
    checks++; if (beats.size() != 1) begin errors++; $display("FAIL unc_beats: got %0d expected 1", beats.size()); end
    checks++; if (beats.size() > 0 && beats[0] !== 32'h2000_0008) begin
      errors++; $display("FAIL unc_addr: got %h expected 20000008", beats[0]); end
    checks++; if (blk !== {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}) begin
      errors++; $display("FAIL unc_blk: got %h expected 00000000deadbeef0000000000000000", blk); end
    checks++; if (vcyc != t + 3) begin errors++; $display("FAIL unc_latency: got %0d expected 3", vcyc - t); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL unc_valid_cycles: got %0d expected 1", vcnt); end
    data_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    int t, vcyc, vcnt; bit ok; logic [127:0] blk;
    data_mode = 1'b0;
    stall_word = 1; stall_left = 3; stall_seen = 0; stall_bad = 0;
    start_req(32'h0000_1000, 1'b0, t, ok);
    run_observe(25, vcyc, vcnt, blk);
    stall_word = -1;
    checks++; if (stall_seen != 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_addr_stable: got %0d changes expected 0", stall_bad); end
    checks++; if (beats.size() != 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", beats.size()); end
    checks++; if (beats.size() > 1 && beats[1] !== 32'h0000_1004) begin
      errors++; $display("FAIL bp_addr1: got %h expected 00001004", beats[1]); end
    checks++; if (blk !== {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000}) begin
      errors++; $display("FAIL bp_blk: got %h expected 0000100c000010080000100400001000", blk); end
    checks++; if (vcyc != t + 12) begin errors++; $display("FAIL bp_latency: got %0d expected 12", vcyc - t); end
  endtask

  task automatic test_back_to_back();
    int t, busy, vc1, vc2; logic rdy10; logic [127:0] blk2;
    data_mode = 1'b0; busy = 0; vc1 = -1; vc2 = -1; rdy10 = 1'b0; blk2 = '0;
    for (int i = 0; i < 20; i++) begin
      if (res.ready) break;
      tick();
    end
    beats.delete(); word_cnt = 0;
    req = '{valid: 1'b1, ready: 1'b1, addr: 32'h4000_0000, uncached: 1'b0};
    t = cyc;
    tick();
    req.addr = 32'h4000_0104; req.uncached = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (cyc == t + 11) req.valid = 1'b0;
      if (cyc <= t + 9 && res.ready) busy++;
      if (cyc == t + 10) rdy10 = res.ready;
      if (res.valid) begin
        if (vc1 < 0) vc1 = cyc;
        else if (vc2 < 0) begin vc2 = cyc; blk2 = res.blk; end
      end
      tick();
    end
    req.valid = 1'b0;
    checks++; if (busy != 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d ready cycles expected 0", busy); end
    checks++; if (rdy10 !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b expected 1", rdy10); end
    checks++; if (vc1 != t + 9) begin errors++; $display("FAIL b2b_valid1: got %0d expected 9", vc1 - t); end
    checks++; if (vc2 != t + 13) begin errors++; $display("FAIL b2b_valid2: got %0d expected 13", vc2 - t); end
    checks++; if (blk2 !== {32'h0, 32'h0, 32'h4000_0104, 32'h0}) begin
      errors++; $display("FAIL b2b_blk2: got %h expected 00000000000000004000010400000000", blk2); end
    checks++; if (beats.size() != 5) begin errors++; $display("FAIL b2b_beats: got %0d expected 5", beats.size()); end
  endtask

  task automatic test_reset_mid_refill();
    int t, vcyc, vcnt; bit ok; logic [127:0] blk;
    data_mode = 1'b0;
    start_req(32'h8000_0014, 1'b0, t, ok);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (beats.size() != 3 || mem_rvalid !== 1'b1) begin
      errors++; $display("FAIL rst_setup: got %0d beats rvalid %b expected 3 beats rvalid 1", beats.size(), mem_rvalid); end
    rst_n = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (res.valid !== 1'b0 || res.ready !== 1'b0) begin
      errors++; $display("FAIL rst_handshake: got valid %b ready %b expected 0 0", res.valid, res.ready); end
    checks++; if (res.blk !== 128'h0) begin errors++; $display("FAIL rst_blk: got %h expected 0", res.blk); end
    pend = 1'b0;
    @(posedge clk); #1; cyc++;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1; cyc++;
    mem_rvalid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (res.ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", res.ready); end
    checks++; if (res.blk !== 128'h0 || res.valid !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid: got blk %h valid %b expected 0 0", res.blk, res.valid); end
    start_req(32'h8000_0014, 1'b0, t, ok);
    run_observe(20, vcyc, vcnt, blk);
    checks++; if (blk !== {32'h8000_001C, 32'h8000_0018, 32'h8000_0014, 32'h8000_0010}) begin
      errors++; $display("FAIL rst_next_blk: got %h expected 8000001c800000188000001480000010", blk); end
    checks++; if (vcyc != t + 9 || vcnt != 1) begin
      errors++; $display("FAIL rst_next_valid: got latency %0d count %0d expected 9 1", vcyc - t, vcnt); end
  endtask

  initial begin
    test_reset();
    test_cached();
    test_uncached();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_refill_responder.md
IMEM_REFILL_RESPONDER -- requirements
Module: imem_refill_responder

Interface
REQ-001 The block SHALL have parameter BLK_SIZE, default ceres_param::BLK_SIZE, meaning cache-line width in bits.
REQ-002 The block SHALL have parameter XLEN, default ceres_param::XLEN, meaning memory word width in bits.
REQ-003 The block SHALL have input clk_i, 1 bit: the single clock.
REQ-004 The block SHALL have input rst_ni, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input lx_ireq_i, type ilowX_req_t: refill request with fields valid, ready, addr, uncached.
REQ-006 The block SHALL have output lx_ires_o, type ilowX_res_t: refill response with fields valid, ready, blk[BLK_SIZE-1:0].
REQ-007 The block SHALL have output mem_req_o, 1 bit: word read request to backing memory.
REQ-008 The block SHALL have output mem_addr_o, XLEN bits: word-aligned byte address of the read.
REQ-009 The block SHALL have input mem_gnt_i, 1 bit: memory accepted the mem_req_o/mem_addr_o beat.
REQ-010 The block SHALL have input mem_rvalid_i, 1 bit: read data valid.
REQ-011 The block SHALL have input mem_rdata_i, XLEN bits: read data.

Function
REQ-012 WORDS SHALL equal BLK_SIZE/XLEN, and WORDS SHALL be a power of two that is at least 2; any other value SHALL be an elaboration error.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, and SHALL allow at most one memory read outstanding at any time.
REQ-014 lx_ires_o.ready SHALL be 1 only in IDLE, and a request SHALL be accepted in a cycle where lx_ireq_i.valid and lx_ires_o.ready are both 1.
REQ-015 On acceptance, the block SHALL latch a line base of addr with the low log2(BLK_SIZE/8) bits cleared, the word index addr[log2(BLK_SIZE/8)-1:2], and the uncached flag, then go to ISSUE.
REQ-016 In ISSUE, mem_req_o SHALL be 1 and mem_addr_o SHALL equal base+4*cnt for cached requests, or base+4*word index for uncached requests.
REQ-017 In ISSUE, the FSM SHALL go to WAIT on mem_gnt_i and SHALL stay in ISSUE with address held stable while mem_gnt_i is 0.
REQ-018 In WAIT, mem_req_o SHALL be 0, and on mem_rvalid_i the block SHALL write mem_rdata_i into blk[lane*XLEN +: XLEN].
REQ-019 The lane written in WAIT SHALL be cnt for cached requests and the word index for uncached requests.
REQ-020 After a cached word, cnt SHALL increment, and the FSM SHALL go to RESP when cnt==WORDS-1, otherwise back to ISSUE; cnt SHALL wrap to 0 on entering RESP.
REQ-021 An uncached request SHALL perform exactly one read, and all other lanes of blk SHALL be 0.
REQ-022 In RESP, lx_ires_o.valid SHALL be 1 for exactly one cycle with blk stable, then the FSM SHALL return to IDLE; lx_ires_o.valid SHALL be 0 in all other states.
REQ-023 The line buffer SHALL be cleared on acceptance so that no stale data from a prior line reaches blk.
REQ-024 lx_ireq_i.valid in ISSUE, WAIT, or RESP SHALL be ignored, with no queueing; the requester holds valid until ready.
REQ-025 With zero-wait memory (gnt in the same cycle as req, rvalid in the next cycle), acceptance at cycle T SHALL give valid at T+1+2*WORDS for cached requests and T+3 for uncached requests.
REQ-026 mem_rvalid_i outside WAIT SHALL be ignored and SHALL be flagged by an assertion.
REQ-027 lx_ireq_i.ready SHALL be unused, because the cache always consumes the response.
REQ-028 No flush input SHALL exist, and an accepted request SHALL always complete.

Reset
REQ-029 On rst_ni=0, asynchronously, the block SHALL set state=IDLE, cnt=0, line buffer=0, latched address/flags=0, mem_req_o=0, and lx_ires_o.valid=0.
REQ-030 lx_ires_o.ready SHALL be 0 while rst_ni=0 and 1 from the first cycle after deassertion.
REQ-031 Reset asserted mid-refill SHALL abandon the transaction; a late mem_rvalid_i arriving after reset SHALL be ignored.

Structure
REQ-032 ilowX_req_t and ilowX_res_t SHALL be reused unchanged from ceres_param.
REQ-033 A new enum imem_rsp_state_e {IDLE, ISSUE, WAIT, RESP} SHALL be added to ceres_param.
REQ-034 No sub-module SHALL be used: the FSM, counter, and line buffer form one flat module.

Verification
REQ-035 The bench SHALL cover a cached zero-wait refill: addr 0x8000_0014, BLK_SIZE=128, memory word = address -> mem_addr_o sequence 0x...10/14/18/1C, blk={0x8000001C,0x80000018,0x80000014,0x80000010}, valid at T+9 for one cycle.
REQ-036 The bench SHALL cover an uncached refill: addr 0x2000_0008, uncached=1, rdata 0xDEADBEEF -> single read at 0x20000008, blk lane 2=0xDEADBEEF, other lanes 0, valid at T+3.
REQ-037 The bench SHALL cover grant backpressure: mem_gnt_i held low 3 cycles on word 1 -> mem_addr_o stable for all 4 cycles, a single read per word, valid delayed by exactly 3 cycles.
REQ-038 The bench SHALL cover back-to-back requests: valid held continuously across two lines -> ready=0 in ISSUE/WAIT/RESP, second acceptance on the first IDLE cycle after RESP, blk of line 2 free of line-1 data.
REQ-039 The bench SHALL cover reset mid-refill: rst_ni low during WAIT of word 2 -> outputs zero immediately, ready=1 the cycle after release, a late rvalid ignored, and the next refill correct.
